// File: rtl/riscv_pkg.sv
// Shared RV32 load/store definitions: funct3 access codes, byte-enable patterns,
// LSU state encoding and small decode helpers used by the load/store unit.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_WAIT = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_t;

    // Unsigned variants only exist for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = !is_store;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: f3_misaligned = off[0];
            F3_W:        f3_misaligned = (off != 2'b00);
            default:     f3_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B, F3_BU: byte_enables = BE_B << off;
            F3_H, F3_HU: byte_enables = BE_H << {off[1], 1'b0};
            default:     byte_enables = BE_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load alignment: selects the addressed byte/halfword lane of the memory word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    // Halfwords only look at byte_off[1]; a stray byte_off[0] is ignored.
    assign byte_sel = lanes[byte_off];
    assign half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack transaction per load/store, stalling the core
// until it completes. Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned H/W accesses.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_st_op,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int               CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    lsu_state_t        state_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              is_store_reg;
    logic [2:0]        funct3_reg;
    logic [1:0]        off_reg;
    logic              req_reg;
    logic              we_reg;
    logic [3:0]        be_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       load_data_reg;
    logic              load_valid_reg;
    logic              bus_err_reg;

    logic              misalign_hit;
    logic              accept_ok;
    logic              start;
    logic              reject;
    logic [31:0]       wdata_next;
    logic [31:0]       aligned_data;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_hit = f3_misaligned(funct3, addr[1:0]);
`else
    assign misalign_hit = 1'b0;
`endif

    assign accept_ok = f3_legal(funct3, mem_write) && !misalign_hit;
    assign start     = (state_reg == LSU_IDLE) && ld_st_op && accept_ok;
    assign reject    = (state_reg == LSU_IDLE) && ld_st_op && !accept_ok;

    // Stall begins in the accepting IDLE cycle; RESP lets the core advance.
    assign stall   = start || (state_reg == LSU_WAIT);
    assign bus_err = bus_err_reg || reject;

    always_comb begin
        wdata_next = store_data;
        case (funct3)
            F3_B:    wdata_next = {4{store_data[7:0]}};
            F3_H:    wdata_next = {2{store_data[15:0]}};
            default: wdata_next = store_data;
        endcase
    end

    lsu_load_align u_load_align (
        .rdata    (mem_rdata),
        .byte_off (off_reg),
        .funct3   (funct3_reg),
        .data     (aligned_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= LSU_IDLE;
            count_reg      <= '0;
            is_store_reg   <= 1'b0;
            funct3_reg     <= 3'd0;
            off_reg        <= 2'd0;
            req_reg        <= 1'b0;
            we_reg         <= 1'b0;
            be_reg         <= 4'd0;
            addr_reg       <= '0;
            wdata_reg      <= 32'd0;
            load_data_reg  <= 32'd0;
            load_valid_reg <= 1'b0;
            bus_err_reg    <= 1'b0;
        end else begin
            load_valid_reg <= 1'b0;
            bus_err_reg    <= 1'b0;
            case (state_reg)
                LSU_IDLE: begin
                    if (start) begin
                        state_reg    <= LSU_WAIT;
                        count_reg    <= '0;
                        is_store_reg <= mem_write;
                        funct3_reg   <= funct3;
                        off_reg      <= addr[1:0];
                        req_reg      <= 1'b1;
                        we_reg       <= mem_write;
                        be_reg       <= byte_enables(funct3, addr[1:0]);
                        addr_reg     <= {addr[ADDR_W-1:2], 2'b00};
                        wdata_reg    <= wdata_next;
                    end
                end
                LSU_WAIT: begin
                    count_reg <= count_reg + 1'b1;
                    if (mem_ack) begin
                        state_reg <= LSU_RESP;
                        req_reg   <= 1'b0;
                        we_reg    <= 1'b0;
                        be_reg    <= 4'd0;
                        if (!is_store_reg) begin
                            load_data_reg  <= aligned_data;
                            load_valid_reg <= 1'b1;
                        end
                    end else if ((TIMEOUT != 0) && (count_reg == CNT_LIMIT)) begin
                        state_reg   <= LSU_RESP;
                        req_reg     <= 1'b0;
                        we_reg      <= 1'b0;
                        be_reg      <= 4'd0;
                        bus_err_reg <= 1'b1;
                    end
                end
                LSU_RESP: state_reg <= LSU_IDLE;
                default:  state_reg <= LSU_IDLE;
            endcase
        end
    end

    assign mem_req    = req_reg;
    assign mem_we     = we_reg;
    assign mem_be     = be_reg;
    assign mem_addr   = addr_reg;
    assign mem_wdata  = wdata_reg;
    assign load_data  = load_data_reg;
    assign load_valid = load_valid_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: the bench plays both core and memory,
// running one transaction at a time with hand-computed expectations.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        ld_st_op;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    int          r_stall;
    bit          r_lv;
    bit          r_err;
    bit          r_req_seen;
    bit          r_req_end;
    bit          r_we;
    logic [3:0]  r_be;
    logic [31:0] r_maddr;
    logic [31:0] r_wdata;
    logic [31:0] r_ld;

    load_store_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_st_op   (ld_st_op),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    // Move to 1 ns after the next rising edge (input drive point).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction and act as memory; ack arrives in the (ack_wait+1)-th
    // request cycle, ack_wait<0 means never. Returns once the core may advance.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input int ack_wait, input logic [31:0] rd);
        int wait_n;
        bit done;
        ld_st_op   = 1'b1;
        mem_write  = we;
        funct3     = f3;
        addr       = a;
        store_data = d;
        r_stall = 0; r_lv = 0; r_err = 0; r_req_seen = 0; r_req_end = 0; r_we = 0;
        r_be = '0; r_maddr = '0; r_wdata = '0; r_ld = '0;
        wait_n = 0;
        done   = 0;
        #2;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (stall) r_stall++;
            if (load_valid) begin r_lv = 1; r_ld = load_data; end
            if (bus_err) r_err = 1;
            if (mem_req) begin
                if (!r_req_seen) begin
                    r_be = mem_be; r_maddr = mem_addr; r_wdata = mem_wdata; r_we = mem_we;
                end
                r_req_seen = 1;
                if (wait_n == ack_wait) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                end
                wait_n++;
            end
            if (!stall) begin
                done      = 1;
                r_req_end = mem_req;
            end
            step();
            mem_ack = 1'b0;
            if (done) ld_st_op = 1'b0;
            #2;
        end
        chk("txn_completes", 32'(done), 32'd1);
        $display("txn we=%0b f3=%03b addr=0x%08h stall=%0d lv=%0b err=%0b be=%04b", we, f3, a,
                 r_stall, r_lv, r_err, r_be);
    endtask

    task automatic check_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_data);
        step();
        run_txn(1'b0, f3, a, 32'h0, 0, 32'h80FF_1234);
        chk({tag, "_be"}, 32'(r_be), 32'(exp_be));
        chk({tag, "_addr"}, r_maddr, exp_addr);
        chk({tag, "_we"}, 32'(r_we), 32'd0);
        chk({tag, "_valid"}, 32'(r_lv), 32'd1);
        chk({tag, "_data"}, r_ld, exp_data);
        chk({tag, "_stall"}, 32'(r_stall), 32'd2);
        chk({tag, "_pulse"}, 32'(load_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; ld_st_op = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = '0; store_data = '0; mem_rdata = '0; mem_ack = 1'b0;
        step(); step();
        #2;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_lv", 32'(load_valid), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk("rst_ldata", load_data, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        step();
        rst = 1'b0;

        // SW with ack in the third request cycle: four stall cycles.
        step();
        run_txn(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 2, 32'h0);
        chk("sw_be", 32'(r_be), 32'h0000_000F);
        chk("sw_addr", r_maddr, 32'h0000_0104);
        chk("sw_wdata", r_wdata, 32'hDEAD_BEEF);
        chk("sw_we", 32'(r_we), 32'd1);
        chk("sw_stall", 32'(r_stall), 32'd4);
        chk("sw_no_lv", 32'(r_lv), 32'd0);
        chk("sw_no_err", 32'(r_err), 32'd0);
        chk("sw_req_drop", 32'(r_req_end), 32'd0);

        check_load("lb",  3'b000, 32'h0000_0203, 32'h0000_0200, 4'b1000, 32'hFFFF_FF80);
        check_load("lbu", 3'b100, 32'h0000_0203, 32'h0000_0200, 4'b1000, 32'h0000_0080);
        check_load("lh",  3'b001, 32'h0000_0202, 32'h0000_0200, 4'b1100, 32'hFFFF_80FF);
        check_load("lhu", 3'b101, 32'h0000_0202, 32'h0000_0200, 4'b1100, 32'h0000_80FF);
        check_load("lw",  3'b010, 32'h0000_0200, 32'h0000_0200, 4'b1111, 32'h80FF_1234);
        check_load("lb0", 3'b000, 32'h0000_0200, 32'h0000_0200, 4'b0001, 32'h0000_0034);

        step();
        run_txn(1'b1, 3'b001, 32'h0000_0012, 32'h0000_ABCD, 0, 32'h0);
        chk("sh_be", 32'(r_be), 32'h0000_000C);
        chk("sh_wdata", r_wdata, 32'hABCD_ABCD);
        chk("sh_addr", r_maddr, 32'h0000_0010);

        step();
        run_txn(1'b1, 3'b000, 32'h0000_0101, 32'h1234_565A, 0, 32'h0);
        chk("sb_be", 32'(r_be), 32'h0000_0002);
        chk("sb_wdata", r_wdata, 32'h5A5A_5A5A);
        chk("sb_stall", 32'(r_stall), 32'd2);
        chk("ldata_hold", load_data, 32'h0000_0034);

        // Illegal funct3 is rejected in the IDLE cycle itself.
        step();
        run_txn(1'b0, 3'b011, 32'h0000_0040, 32'h0, 0, 32'h0);
        chk("ill_err", 32'(r_err), 32'd1);
        chk("ill_stall", 32'(r_stall), 32'd0);
        chk("ill_noreq", 32'(r_req_seen), 32'd0);
        chk("ill_err_pulse", 32'(bus_err), 32'd0);

        step();
        run_txn(1'b1, 3'b100, 32'h0000_0040, 32'h0, 0, 32'h0);
        chk("ill_st_err", 32'(r_err), 32'd1);
        chk("ill_st_noreq", 32'(r_req_seen), 32'd0);

        step();
        run_txn(1'b0, 3'b010, 32'h0000_0002, 32'h0, 0, 32'h1122_3344);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_err", 32'(r_err), 32'd1);
        chk("mis_noreq", 32'(r_req_seen), 32'd0);
        chk("mis_stall", 32'(r_stall), 32'd0);
        chk("mis_ldata", load_data, 32'h0000_0034);
`else
        chk("mis_addr", r_maddr, 32'h0000_0000);
        chk("mis_be", 32'(r_be), 32'h0000_000F);
        chk("mis_data", r_ld, 32'h1122_3344);
        chk("mis_no_err", 32'(r_err), 32'd0);
`endif

        // No ack: TIMEOUT=4 gives five request cycles plus the IDLE cycle.
        step();
        run_txn(1'b0, 3'b010, 32'h0000_0500, 32'h0, -1, 32'h0);
        chk("to_err", 32'(r_err), 32'd1);
        chk("to_no_lv", 32'(r_lv), 32'd0);
        chk("to_stall", 32'(r_stall), 32'd6);
        chk("to_req_drop", 32'(r_req_end), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        step();
        mem_ack = 1'b0;
        #2;
        chk("late_ack_lv", 32'(load_valid), 32'd0);
        chk("late_ack_req", 32'(mem_req), 32'd0);
        chk("late_ack_err", 32'(bus_err), 32'd0);

        // Reset while waiting for ack.
        step();
        ld_st_op = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0300;
        step();
        #2;
        chk("rw_req", 32'(mem_req), 32'd1);
        chk("rw_stall", 32'(stall), 32'd1);
        step();
        rst = 1'b1;
        ld_st_op = 1'b0;
        step();
        rst = 1'b0;
        #2;
        chk("rw_req_drop", 32'(mem_req), 32'd0);
        chk("rw_stall_drop", 32'(stall), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        step();
        mem_ack = 1'b0;
        #2;
        chk("rw_ack_ignored", 32'(load_valid), 32'd0);
        chk("rw_ldata", load_data, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
